// File: rtl/buttons_debounce_wb.sv
// Wishbone slave reporting debounced push-button state plus sticky press/release
// event flags that clear when read. Buttons are active-low; all logic is on clk.
module buttons_debounce_wb #(
  parameter int unsigned N_BTN      = 2,
  parameter int unsigned DEBOUNCE_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn,
  input  logic             wb_cyc,
  input  logic             wb_we,
  output logic [31:0]      wb_rdata,
  output logic             wb_ack
);

  localparam logic [DEBOUNCE_W-1:0] CntMax = '1;

  logic [N_BTN-1:0] sync1_q, sync2_q;
  logic [N_BTN-1:0] stable_q, stable_d;
  logic [N_BTN-1:0] press_evt_q, press_evt_d;
  logic [N_BTN-1:0] release_evt_q, release_evt_d;
  logic [N_BTN-1:0] press_set, release_set;
  logic             ack_q, ack_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      rd_word;
  logic             rd_take;

  // Two-flop synchroniser; released (all ones) out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_debounce
    logic [DEBOUNCE_W-1:0] cnt_q, cnt_d;

    // Any sample that agrees with the accepted level restarts the stability count.
    always_comb begin
      cnt_d       = cnt_q;
      stable_d[i] = stable_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d = '0;
      end else if (cnt_q == CntMax) begin
        stable_d[i] = sync2_q[i];
        cnt_d       = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q       <= '0;
        stable_q[i] <= 1'b1;
      end else begin
        cnt_q       <= cnt_d;
        stable_q[i] <= stable_d[i];
      end
    end
  end

  assign press_set   = stable_q & ~stable_d;
  assign release_set = ~stable_q & stable_d;

  // A read is taken on the edge that raises ack; that edge loads rdata and clears events.
  assign rd_take = wb_cyc & ~ack_q & ~wb_we;

  always_comb begin
    rd_word                 = '0;
    rd_word[N_BTN-1:0]      = ~stable_q;
    rd_word[8 +: N_BTN]     = press_evt_q;
    rd_word[16 +: N_BTN]    = release_evt_q;
  end

  // A new event landing on the clearing edge survives for the next read.
  always_comb begin
    press_evt_d   = (rd_take ? '0 : press_evt_q) | press_set;
    release_evt_d = (rd_take ? '0 : release_evt_q) | release_set;
    ack_d         = wb_cyc & ~ack_q;
    rdata_d       = rd_take ? rd_word : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      press_evt_q   <= '0;
      release_evt_q <= '0;
      ack_q         <= 1'b0;
      rdata_q       <= 32'h0;
    end else begin
      press_evt_q   <= press_evt_d;
      release_evt_q <= release_evt_d;
      ack_q         <= ack_d;
      rdata_q       <= rdata_d;
    end
  end

  assign wb_ack   = ack_q;
  assign wb_rdata = rdata_q;

endmodule

// File: tb/tb_buttons_debounce_wb.sv
// Self-checking bench for buttons_debounce_wb: directed scenarios followed by random
// button/bus activity compared against a window-based reference model every cycle.
module tb_buttons_debounce_wb;

  localparam int unsigned NB  = 2;
  localparam int unsigned DW  = 4;
  localparam int unsigned WIN = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NB-1:0] btn = '1;
  logic          wb_cyc = 1'b0;
  logic          wb_we = 1'b0;
  logic [31:0]   wb_rdata;
  logic          wb_ack;

  int checks = 0;
  int failures = 0;

  // Reference state: a button's accepted level flips once the last WIN synchronised
  // samples all disagree with it; synchronised sample at edge E is btn seen at edge E-2.
  logic [NB-1:0] m_stable, m_press, m_rel;
  logic          m_ack;
  logic [31:0]   m_rdata;
  logic [NB-1:0] hist[$];

  always #5 clk = ~clk;

  buttons_debounce_wb #(
    .N_BTN      (NB),
    .DEBOUNCE_W (DW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn      (btn),
    .wb_cyc   (wb_cyc),
    .wb_we    (wb_we),
    .wb_rdata (wb_rdata),
    .wb_ack   (wb_ack)
  );

  function automatic logic sync_at(input int idx, input int b);
    logic [NB-1:0] v;
    if (idx < 0) return 1'b1;
    v = hist[idx];
    return v[b];
  endfunction

  task automatic model_edge();
    logic [NB-1:0] new_stable, set_p, set_r;
    logic [31:0]   word;
    logic          take;
    int            n;
    if (reset) begin
      m_stable = '1;
      m_press  = '0;
      m_rel    = '0;
      m_ack    = 1'b0;
      m_rdata  = 32'h0;
      hist.delete();
      return;
    end
    n = hist.size();
    new_stable = m_stable;
    for (int b = 0; b < NB; b++) begin
      bit all_diff = 1'b1;
      for (int k = 0; k < WIN; k++) begin
        if (sync_at(n - 2 - k, b) === m_stable[b]) all_diff = 1'b0;
      end
      if (all_diff) new_stable[b] = ~m_stable[b];
    end
    set_p = m_stable & ~new_stable;
    set_r = ~m_stable & new_stable;
    take  = wb_cyc & ~m_ack & ~wb_we;
    word  = 32'h0;
    word[NB-1:0]  = ~m_stable;
    word[8 +: NB] = m_press;
    word[16 +: NB] = m_rel;
    m_rdata = take ? word : 32'h0;
    if (take) begin
      m_press = '0;
      m_rel   = '0;
    end
    m_press  = m_press | set_p;
    m_rel    = m_rel | set_r;
    m_ack    = wb_cyc & ~m_ack;
    m_stable = new_stable;
    hist.push_back(btn);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("ack_vs_model", {31'h0, wb_ack}, {31'h0, m_ack});
    chk("rdata_vs_model", wb_rdata, m_rdata);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wb_read(input logic [31:0] exp, input string tag);
    wb_cyc = 1'b1;
    wb_we  = 1'b0;
    tick();
    chk({tag, "_ack"}, {31'h0, wb_ack}, 32'h1);
    chk(tag, wb_rdata, exp);
    wb_cyc = 1'b0;
    tick();
    chk({tag, "_ack_drop"}, {31'h0, wb_ack}, 32'h0);
  endtask

  task automatic wb_write(input string tag);
    wb_cyc = 1'b1;
    wb_we  = 1'b1;
    tick();
    chk({tag, "_ack"}, {31'h0, wb_ack}, 32'h1);
    chk({tag, "_rdata"}, wb_rdata, 32'h0);
    wb_cyc = 1'b0;
    wb_we  = 1'b0;
    tick();
  endtask

  initial begin
    // Reset and idle read
    reset = 1'b1;
    btn   = '1;
    ticks(3);
    reset = 1'b0;
    tick();
    chk("reset_ack", {31'h0, wb_ack}, 32'h0);
    chk("reset_rdata", wb_rdata, 32'h0);
    wb_read(32'h0000_0000, "reset_read");

    // Press A: accepted on the 18th edge after the level is first sampled
    btn[0] = 1'b0;
    ticks(17);
    wb_read(32'h0000_0000, "press_edge18");
    wb_read(32'h0000_0101, "press_evt");
    wb_read(32'h0000_0001, "press_cleared");

    // Release A, then glitches on B
    btn[0] = 1'b1;
    ticks(30);
    wb_read(32'h0001_0000, "release_evt");
    repeat (5) begin
      btn[1] = 1'b0;
      ticks(10);
      btn[1] = 1'b1;
      ticks(1);
    end
    ticks(20);
    wb_read(32'h0000_0000, "glitch10");
    btn[1] = 1'b0;
    ticks(15);
    btn[1] = 1'b1;
    ticks(30);
    wb_read(32'h0000_0000, "glitch15");
    btn[1] = 1'b0;
    ticks(16);
    btn[1] = 1'b1;
    ticks(40);
    wb_read(32'h0002_0200, "pulse16");

    // Press and release without a read in between
    btn[0] = 1'b0;
    ticks(30);
    btn[0] = 1'b1;
    ticks(30);
    wb_read(32'h0001_0100, "press_release");
    wb_read(32'h0000_0000, "pr_cleared");

    // Writes leave event flags untouched
    btn[0] = 1'b0;
    ticks(30);
    wb_write("write");
    wb_read(32'h0000_0101, "after_write");
    btn[0] = 1'b1;
    ticks(30);
    wb_read(32'h0001_0000, "after_write_rel");

    // Reset with an event pending and A's count mid-way
    btn[1] = 1'b0;
    ticks(30);
    btn[0] = 1'b0;
    ticks(10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wb_read(32'h0000_0000, "post_reset");
    ticks(15);
    wb_read(32'h0000_0000, "restart_edge18");
    wb_read(32'h0000_0303, "restart_evt");

    // Random activity checked against the model every cycle
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 5) begin
        btn[$urandom_range(0, NB - 1)] = $urandom_range(0, 1);
        ticks($urandom_range(1, 40));
      end else if (r < 8) begin
        wb_cyc = 1'b1;
        wb_we  = $urandom_range(0, 1);
        ticks($urandom_range(1, 3));
        wb_cyc = 1'b0;
        wb_we  = 1'b0;
        tick();
      end else if (r == 8) begin
        wb_cyc = $urandom_range(0, 1);
        wb_we  = $urandom_range(0, 1);
        tick();
        wb_cyc = 1'b0;
        wb_we  = 1'b0;
        tick();
      end else if ($urandom_range(0, 4) == 0) begin
        wb_cyc = $urandom_range(0, 1);
        reset  = 1'b1;
        tick();
        reset  = 1'b0;
        wb_cyc = 1'b0;
        tick();
      end else begin
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
